// File: rtl/alu_arbiter_sequencer.sv
// ============================================================================
// Module      : alu_arbiter_sequencer
// Description : Round-robin sharing of one registered ALU between two
//               requesters, with a single tagged valid/ready response channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter_sequencer #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6,
    parameter int MAX_OP = 23
) (
    input  logic              alu_clk,
    input  logic              alu_rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [CTRL_W-1:0] r0_op,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [CTRL_W-1:0] r1_op,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] alu_in_1,
    output logic [DATA_W-1:0] alu_in_2,
    input  logic [DATA_W-1:0] alu_rslt,
    input  logic [3:0]        alu_checks
);

    localparam logic [CTRL_W-1:0] c_max_op    = CTRL_W'(MAX_OP);
    localparam logic [3:0]        c_err_flags = 4'b0100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [3:0]          rsp_flags_q, rsp_flags_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0]   alu_in_1_q, alu_in_1_d;
    logic [DATA_W-1:0]   alu_in_2_q, alu_in_2_d;

    logic                w_winner;
    logic                w_accept;
    logic                w_illegal;
    logic [CTRL_W-1:0]   w_op;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;

    // Tie goes to the pointer; a lone requester wins regardless of it.
    assign w_winner  = (r0_valid && r1_valid) ? rr_ptr_q : r1_valid;
    assign w_accept  = (state_q == S_IDLE) && (r0_valid || r1_valid) && !alu_rst;
    assign w_op      = w_winner ? r1_op : r0_op;
    assign w_a       = w_winner ? r1_a  : r0_a;
    assign w_b       = w_winner ? r1_b  : r0_b;
    assign w_illegal = (w_op > c_max_op);

    assign r0_ready  = w_accept && !w_winner;
    assign r1_ready  = w_accept &&  w_winner;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        alu_ctrl_d  = alu_ctrl_q;
        alu_in_1_d  = alu_in_1_q;
        alu_in_2_d  = alu_in_2_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    rr_ptr_d = ~w_winner;
                    rsp_id_d = w_winner;
                    if (w_illegal) begin
                        // Bypass the ALU entirely so its inputs stay quiet.
                        rsp_data_d  = '0;
                        rsp_flags_d = c_err_flags;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        alu_ctrl_d  = w_op;
                        alu_in_1_d  = w_a;
                        alu_in_2_d  = w_b;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                rsp_data_d  = alu_rslt;
                rsp_flags_d = alu_checks;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge alu_clk or posedge alu_rst) begin
        if (alu_rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
            alu_ctrl_q  <= '0;
            alu_in_1_q  <= '0;
            alu_in_2_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_in_1_q  <= alu_in_1_d;
            alu_in_2_q  <= alu_in_2_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign alu_in_1  = alu_in_1_q;
    assign alu_in_2  = alu_in_2_q;

endmodule

`default_nettype wire
